filter_mac_writer: RTL and testbench

//  Convolution stage feeding the filter-output RAM. Streams pixels, multiplies by a

---
 rtl/filter_mac_writer.sv | 217 +++++++++++++++++++++
 tb/tb_filter_mac_writer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_mac_writer.sv
// -----------------------------------------------------------------------------
// filter_mac_writer
//
// Convolution stage that feeds the filter-output RAM. Pixels are streamed in
// and multiplied by a stored signed kernel. TAPS products are accumulated for
// each output. The sum is then shifted arithmetically right by SHIFT, clamped
// to 8 bits, and written to the RAM at sequential addresses starting from 0.
// After NUM_OUT results have been written, a single done pulse ends the run.
//
// Build option:
//   FILTER_RELU_EN  defined   -> a negative shifted result is written as 0 (ReLU)
//                   undefined -> a negative result is written as its magnitude,
//                                saturated at 255
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   start      begins a run; sampled only while idle
//   coef_we    kernel coefficient write strobe; honoured only while idle
//   coef_addr  tap index for coef_we; indices >= TAPS are ignored
//   coef_data  signed two's-complement coefficient
//   pix_valid  pix_data is valid
//   pix_data   unsigned pixel
//   pix_ready  the stage accepts a pixel this cycle
//   wr         RAM write strobe; high for one cycle per result
//   nextaddr   RAM write address; valid while wr=1
//   data_out   RAM write data; valid while wr=1
//   busy       high in every state except IDLE
//   done       one-cycle pulse at the end of a run
// -----------------------------------------------------------------------------
module filter_mac_writer #(
    parameter int TAPS    = 9,
    parameter int NUM_OUT = 9,
    parameter int ACC_W   = 21,
    parameter int SHIFT   = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       coef_we,
    input  logic [3:0] coef_addr,
    input  logic [7:0] coef_data,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    output logic       wr,
    output logic [7:0] nextaddr,
    output logic [7:0] data_out,
    output logic       busy,
    output logic       done
);

    localparam logic [4:0] LAST_TAP = 5'(TAPS - 1);
    localparam logic [4:0] TAPS_W5  = 5'(TAPS);
    localparam logic [7:0] LAST_OUT = 8'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                   state_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic        [4:0]        tap_cnt_r;
    logic        [7:0]        out_cnt_r;
    logic signed [7:0]        kern_r [TAPS];
    logic                     pix_ready_r;
    logic                     wr_r;
    logic                     done_r;
    logic                     busy_r;
    logic        [7:0]        nextaddr_r;
    logic        [7:0]        data_out_r;

    logic                     accept_s;
    logic signed [16:0]       pix_ext_s;
    logic signed [16:0]       kern_ext_s;
    logic signed [16:0]       prod_s;
    logic signed [ACC_W-1:0]  acc_next_s;
    logic signed [ACC_W-1:0]  shifted_s;

    // Reduce a shifted accumulator value to the 8-bit RAM word.
    function automatic logic [7:0] clamp8(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W:0] ext_v;
        logic signed [ACC_W:0] mag_v;
        clamp8 = 8'd0;
        ext_v  = {v[ACC_W-1], v};
        mag_v  = -ext_v;
        if (v[ACC_W-1] == 1'b1) begin
`ifdef FILTER_RELU_EN
            clamp8 = 8'd0;
`else
            // ext_v is one bit wider than v, so even the most negative value
            // has a representable magnitude.
            if (|mag_v[ACC_W:8]) begin
                clamp8 = 8'd255;
            end else begin
                clamp8 = mag_v[7:0];
            end
`endif
        end else if (|v[ACC_W-2:8]) begin
            clamp8 = 8'd255;
        end else begin
            clamp8 = v[7:0];
        end
    endfunction

    // Multiply-accumulate datapath for the pixel at the current tap.
    always_comb begin
        accept_s   = pix_valid && pix_ready_r;
        pix_ext_s  = {9'd0, pix_data};
        kern_ext_s = {{9{kern_r[tap_cnt_r[3:0]][7]}}, kern_r[tap_cnt_r[3:0]]};
        // The true product always fits in 17 signed bits.
        prod_s     = pix_ext_s * kern_ext_s;
        acc_next_s = acc_r + {{(ACC_W-17){prod_s[16]}}, prod_s};
        shifted_s  = acc_next_s >>> SHIFT;
    end

    // Kernel coefficient storage; writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                kern_r[i] <= 8'sd0;
            end
        end else if (coef_we && (state_r == ST_IDLE) && ({1'b0, coef_addr} < TAPS_W5)) begin
            kern_r[coef_addr] <= coef_data;
        end
    end

    // Control FSM. The outputs are registered here together with the next
    // state, so each one decodes the state it accompanies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            acc_r       <= '0;
            tap_cnt_r   <= 5'd0;
            out_cnt_r   <= 8'd0;
            pix_ready_r <= 1'b0;
            wr_r        <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            nextaddr_r  <= 8'd0;
            data_out_r  <= 8'd0;
        end else begin
            wr_r       <= 1'b0;
            done_r     <= 1'b0;
            nextaddr_r <= 8'd0;
            data_out_r <= 8'd0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r     <= ST_ACC;
                        acc_r       <= '0;
                        tap_cnt_r   <= 5'd0;
                        out_cnt_r   <= 8'd0;
                        pix_ready_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        pix_ready_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                ST_ACC: begin
                    if (accept_s) begin
                        acc_r     <= acc_next_s;
                        tap_cnt_r <= tap_cnt_r + 5'd1;
                        if (tap_cnt_r == LAST_TAP) begin
                            // The result is computed from the final sum here,
                            // so it is on data_out during the write cycle.
                            state_r     <= ST_WRITE;
                            pix_ready_r <= 1'b0;
                            wr_r        <= 1'b1;
                            nextaddr_r  <= out_cnt_r;
                            data_out_r  <= clamp8(shifted_s);
                        end else begin
                            pix_ready_r <= 1'b1;
                        end
                    end else begin
                        pix_ready_r <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    acc_r     <= '0;
                    tap_cnt_r <= 5'd0;
                    if (out_cnt_r == LAST_OUT) begin
                        state_r     <= ST_DONE;
                        done_r      <= 1'b1;
                        pix_ready_r <= 1'b0;
                    end else begin
                        out_cnt_r   <= out_cnt_r + 8'd1;
                        state_r     <= ST_ACC;
                        pix_ready_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    pix_ready_r <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    busy_r      <= 1'b0;
                    pix_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign pix_ready = pix_ready_r;
    assign wr        = wr_r;
    assign nextaddr  = nextaddr_r;
    assign data_out  = data_out_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_filter_mac_writer.sv
// -----------------------------------------------------------------------------
// tb_filter_mac_writer
//
// Directed testbench for filter_mac_writer. It uses two instances that share
// the coefficient and pixel inputs and have separate start inputs:
//   u_dut1 : NUM_OUT=1, for the single-result scenarios
//   u_dut9 : NUM_OUT=9, for the multi-result stream
// Build option FILTER_RELU_EN selects the expected result for negative sums.
// -----------------------------------------------------------------------------
module tb_filter_mac_writer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start1 = 1'b0;
    logic       start9 = 1'b0;
    logic       coef_we = 1'b0;
    logic [3:0] coef_addr = 4'd0;
    logic [7:0] coef_data = 8'd0;
    logic       pix_valid = 1'b0;
    logic [7:0] pix_data = 8'd0;

    logic       pix_ready1, wr1, busy1, done1;
    logic [7:0] nextaddr1, data_out1;
    logic       pix_ready9, wr9, busy9, done9;
    logic [7:0] nextaddr9, data_out9;

    int checks = 0;
    int errors = 0;

    filter_mac_writer #(.TAPS(9), .NUM_OUT(1), .ACC_W(21), .SHIFT(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready1), .wr(wr1),
        .nextaddr(nextaddr1), .data_out(data_out1), .busy(busy1), .done(done1)
    );

    filter_mac_writer #(.TAPS(9), .NUM_OUT(9), .ACC_W(21), .SHIFT(0)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .start(start9), .coef_we(coef_we),
        .coef_addr(coef_addr), .coef_data(coef_data), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready9), .wr(wr9),
        .nextaddr(nextaddr9), .data_out(data_out9), .busy(busy9), .done(done9)
    );

    always #5 clk = ~clk;

    // Write the same coefficient to all nine taps of both instances.
    task automatic load_kernel(input logic [7:0] k);
        for (int i = 0; i < 9; i++) begin
            coef_we   = 1'b1;
            coef_addr = 4'(i);
            coef_data = k;
            @(posedge clk); #1;
        end
        coef_we = 1'b0;
    endtask

    // Run u_dut1 with a constant pixel value and return what was observed.
    // A latency of 0 means the signal was seen in the cycle right after the
    // edge that accepted the ninth pixel.
    task automatic drive_run1(input logic [7:0] pix, output int wr_lat, output int done_lat,
                              output logic [7:0] addr, output logic [7:0] data,
                              output logic rdy_in_wr, output logic busy_after);
        int accepts;
        int last;
        logic will;
        accepts = 0; last = -100; wr_lat = -1; done_lat = -1;
        addr = 8'hxx; data = 8'hxx; rdy_in_wr = 1'bx; busy_after = 1'bx;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        pix_valid = 1'b1;
        pix_data  = pix;
        for (int cyc = 0; cyc < 40; cyc++) begin
            will = pix_valid && pix_ready1;
            @(posedge clk); #1;
            if (will) begin
                accepts++;
                if (accepts == 9) begin
                    last = cyc;
                    pix_valid = 1'b0;
                end
            end
            if (wr1 && wr_lat < 0) begin
                wr_lat = cyc - last; addr = nextaddr1; data = data_out1; rdy_in_wr = pix_ready1;
            end
            if (done1 && done_lat < 0) begin
                done_lat = cyc - last;
            end
            if (done_lat >= 0 && !done1) begin
                busy_after = busy1;
                break;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        int wr_seen;
        rst_n = 1'b0;
        #12;
        checks++;
        if ({wr1, done1, busy1, pix_ready1, nextaddr1, data_out1} !== 20'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0",
                {wr1, done1, busy1, pix_ready1, nextaddr1, data_out1});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_kernel(8'd1);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        pix_valid = 1'b1; pix_data = 8'd10;
        repeat (4) begin @(posedge clk); #1; end
        checks++;
        if (!(busy1 && pix_ready1)) begin
            errors++; $display("FAIL reset_pre_acc: got busy=%b ready=%b expected 1 1", busy1, pix_ready1);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({wr1, done1, busy1, pix_ready1, nextaddr1, data_out1} !== 20'd0) begin
            errors++; $display("FAIL reset_async_abort: got %h expected 0",
                {wr1, done1, busy1, pix_ready1, nextaddr1, data_out1});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr_seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (wr1 || busy1 || pix_ready1) wr_seen++;
        end
        pix_valid = 1'b0;
        checks++;
        if (wr_seen != 0) begin
            errors++; $display("FAIL reset_no_write_after: got %0d active cycles expected 0", wr_seen);
        end
    endtask

    // Kernel all 1, pixel value 10: result 90 at address 0.
    task automatic test_basic();
        int wl, dl; logic [7:0] a, d; logic r, b;
        load_kernel(8'd1);
        drive_run1(8'd10, wl, dl, a, d, r, b);
        checks++;
        if (wl != 0) begin errors++; $display("FAIL basic_wr_latency: got %0d expected 0", wl); end
        checks++;
        if (a !== 8'd0) begin errors++; $display("FAIL basic_addr: got %0d expected 0", a); end
        checks++;
        if (d !== 8'd90) begin errors++; $display("FAIL basic_data: got %0d expected 90", d); end
        checks++;
        if (r !== 1'b0) begin errors++; $display("FAIL basic_ready_in_wr: got %b expected 0", r); end
        checks++;
        if (dl != 1) begin errors++; $display("FAIL basic_done_latency: got %0d expected 1", dl); end
        checks++;
        if (b !== 1'b0) begin errors++; $display("FAIL basic_busy_after: got %b expected 0", b); end
    endtask

    // Kernel all 1, pixel value 255: sum 2295 saturates to 255.
    task automatic test_saturate();
        int wl, dl; logic [7:0] a, d; logic r, b;
        drive_run1(8'd255, wl, dl, a, d, r, b);
        checks++;
        if (d !== 8'd255) begin errors++; $display("FAIL sat_data: got %0d expected 255", d); end
        checks++;
        if (wl != 0) begin errors++; $display("FAIL sat_wr_latency: got %0d expected 0", wl); end
    endtask

    // Kernel all -1, pixel value 5: sum -45.
    task automatic test_negative();
        int wl, dl; logic [7:0] a, d, exp_d; logic r, b;
`ifdef FILTER_RELU_EN
        exp_d = 8'd0;
`else
        exp_d = 8'd45;
`endif
        load_kernel(8'hFF);
        drive_run1(8'd5, wl, dl, a, d, r, b);
        checks++;
        if (d !== exp_d) begin errors++; $display("FAIL neg_data: got %0d expected %0d", d, exp_d); end
        load_kernel(8'd1);
    endtask

    // NUM_OUT=9 with pix_valid toggled every other cycle. Output k uses
    // pixel value k+1, so its expected result is 9*(k+1).
    task automatic test_back_to_back();
        int acc_cnt, wcount, bad, overlap;
        logic will, done_seen;
        acc_cnt = 0; wcount = 0; bad = 0; overlap = 0; done_seen = 1'b0;
        start9 = 1'b1;
        @(posedge clk); #1;
        start9 = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (done_seen) break;
            pix_valid = cyc[0];
            pix_data  = 8'(acc_cnt / 9 + 1);
            will = pix_valid && pix_ready9;
            @(posedge clk); #1;
            if (will) acc_cnt++;
            if ((int'(wr9) + int'(done9) + int'(pix_ready9)) > 1) overlap++;
            if (wr9) begin
                if (nextaddr9 !== 8'(wcount) || data_out9 !== 8'(9 * (wcount + 1)) || pix_ready9 !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_write_%0d: got addr=%0d data=%0d ready=%b expected addr=%0d data=%0d ready=0",
                        wcount, nextaddr9, data_out9, pix_ready9, wcount, 9 * (wcount + 1));
                end
                wcount++;
            end
            if (done9) done_seen = 1'b1;
        end
        pix_valid = 1'b0;
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (wcount != 9) begin errors++; $display("FAIL b2b_wr_count: got %0d expected 9", wcount); end
        checks++;
        if (acc_cnt != 81) begin errors++; $display("FAIL b2b_accepted: got %0d expected 81", acc_cnt); end
        checks++;
        if (!done_seen) begin errors++; $display("FAIL b2b_done: got 0 expected 1"); end
        checks++;
        if (overlap != 0) begin errors++; $display("FAIL b2b_overlap: got %0d expected 0", overlap); end
        @(posedge clk); #1;
    endtask

    // coef_we and start held while u_dut1 is busy must have no effect.
    task automatic test_busy_ignore();
        int accepts, wl, dl; logic [7:0] wdata, a, d; logic r, b, will;
        accepts = 0; wdata = 8'hxx;
        start1 = 1'b1;
        @(posedge clk); #1;
        pix_valid = 1'b1; pix_data = 8'd10;
        for (int i = 0; i < 40; i++) begin
            if (wr1) begin wdata = data_out1; break; end
            coef_we = 1'b1; coef_addr = 4'(i % 9); coef_data = 8'd2;
            will = pix_valid && pix_ready1;
            @(posedge clk); #1;
            if (will) accepts++;
            if (accepts == 9) pix_valid = 1'b0;
        end
        coef_we = 1'b0; pix_valid = 1'b0;
        checks++;
        if (wdata !== 8'd90) begin errors++; $display("FAIL busy_run_data: got %0d expected 90", wdata); end
        // start is still high through WRITE and DONE; only the DONE-cycle edge matters
        @(posedge clk); #1;
        checks++;
        if (done1 !== 1'b1) begin errors++; $display("FAIL busy_done: got %b expected 1", done1); end
        @(posedge clk); #1;
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b0) begin errors++; $display("FAIL start_in_done: got busy=%b expected 0", busy1); end
        @(posedge clk); #1;
        drive_run1(8'd1, wl, dl, a, d, r, b);
        checks++;
        if (d !== 8'd9) begin errors++; $display("FAIL kernel_unchanged: got %0d expected 9", d); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_negative();
        test_back_to_back();
        test_busy_ignore();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
